// File: rtl/geri_yazma_hakemi_pkg.sv
// Shared core definitions: register index width and the {fp, adres}
// scoreboard index used by the write-back arbiter.
package geri_yazma_hakemi_pkg;

  localparam int unsigned REG_ADRES_W = 5;
  localparam int unsigned SB_BOYUT    = 2 ** (REG_ADRES_W + 1);

  typedef logic [REG_ADRES_W:0] sb_indeks_t;

  function automatic sb_indeks_t sb_indeks(input logic fp,
                                           input logic [REG_ADRES_W-1:0] adres);
    return {fp, adres};
  endfunction

  // Integer x0 is hardwired to zero: never written, never reserved.
  function automatic logic x0_mi(input logic fp,
                                 input logic [REG_ADRES_W-1:0] adres);
    return (!fp) && (adres == '0);
  endfunction

endpackage

// File: rtl/geri_yazma_hakemi_dongusel_hakem.sv
// Parameterised round-robin arbiter: request vector in, one-hot grant out.
// The pointer names the highest-priority index and moves past the winner.
module dongusel_hakem #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  istek_i,
  output logic [N-1:0]  izin_o,
  output logic [IW-1:0] kazanan_o,
  output logic          izin_var_o
);

  logic [IW-1:0] oncelik_q;
  logic [IW-1:0] aday;

  // Search upward from the pointer with wrap-around; first valid wins.
  always_comb begin
    izin_o     = '0;
    kazanan_o  = '0;
    izin_var_o = 1'b0;
    aday       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      aday = IW'((32'(oncelik_q) + k) % N);
      if (!izin_var_o && istek_i[aday]) begin
        izin_var_o   = 1'b1;
        izin_o[aday] = 1'b1;
        kazanan_o    = aday;
      end
    end
  end

  // Pointer moves to (winner+1) mod N; holds when nothing is granted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      oncelik_q <= '0;
    end else if (izin_var_o) begin
      if (kazanan_o == IW'(N - 1)) oncelik_q <= '0;
      else                         oncelik_q <= kazanan_o + 1'b1;
    end
  end

endmodule

// File: rtl/geri_yazma_hakemi.sv
// Write-back arbiter and pending-write scoreboard. Grants one unit per cycle
// onto the registered write-back stage and stalls decode on pending operands.
module geri_yazma_hakemi
  import geri_yazma_hakemi_pkg::*;
#(
  parameter int unsigned BIRIM_SAYISI  = 4,
  parameter int unsigned VERI_GENISLIK = 32
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [BIRIM_SAYISI-1:0]                       istek_gecerli_i,
  output logic [BIRIM_SAYISI-1:0]                       istek_hazir_o,
  input  logic [BIRIM_SAYISI-1:0][REG_ADRES_W-1:0]      istek_adres_i,
  input  logic [BIRIM_SAYISI-1:0]                       istek_fp_i,
  input  logic [BIRIM_SAYISI-1:0][VERI_GENISLIK-1:0]    istek_veri_i,
  input  logic                                          ayir_gecerli_i,
  input  logic [REG_ADRES_W-1:0]                        ayir_adres_i,
  input  logic                                          ayir_fp_i,
  input  logic [REG_ADRES_W-1:0]                        rs1_adres_i,
  input  logic [REG_ADRES_W-1:0]                        rs2_adres_i,
  input  logic [REG_ADRES_W-1:0]                        rs3_adres_i,
  input  logic                                          rs1_fp_oku,
  input  logic                                          rs2_fp_oku,
  input  logic                                          rs3_oku_i,
  output logic                                          gy_rd_yaz_o,
  output logic [REG_ADRES_W-1:0]                        gy_rd_adres_o,
  output logic                                          gy_rd_hedef_fp_o,
  output logic [VERI_GENISLIK-1:0]                      gy_veri_o,
  output logic                                          bekle_o
);

  localparam int unsigned IW = (BIRIM_SAYISI > 1) ? $clog2(BIRIM_SAYISI) : 1;

  logic [BIRIM_SAYISI-1:0]  izin;
  logic [IW-1:0]            kazanan;
  logic                     izin_var;
  logic                     aktarim;
  logic [REG_ADRES_W-1:0]   sec_adres;
  logic                     sec_fp;
  logic [VERI_GENISLIK-1:0] sec_veri;
  logic [SB_BOYUT-1:0]      bekleyen_q;
  logic [SB_BOYUT-1:0]      bekleyen_d;

  dongusel_hakem #(
    .N  (BIRIM_SAYISI),
    .IW (IW)
  ) u_hakem (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .istek_i    (istek_gecerli_i),
    .izin_o     (izin),
    .kazanan_o  (kazanan),
    .izin_var_o (izin_var)
  );

  // Grants are suppressed while reset is held so no unit sees a false handshake.
  always_comb begin
    istek_hazir_o = izin & {BIRIM_SAYISI{~rst_i}};
    aktarim       = izin_var & ~rst_i;
    sec_adres     = istek_adres_i[kazanan];
    sec_fp        = istek_fp_i[kazanan];
    sec_veri      = istek_veri_i[kazanan];
  end

  // Write-back stage: load on transfer; x0 is accepted but not written.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gy_rd_yaz_o      <= 1'b0;
      gy_rd_adres_o    <= '0;
      gy_rd_hedef_fp_o <= 1'b0;
      gy_veri_o        <= '0;
    end else if (aktarim) begin
      gy_rd_yaz_o      <= ~x0_mi(sec_fp, sec_adres);
      gy_rd_adres_o    <= sec_adres;
      gy_rd_hedef_fp_o <= sec_fp;
      gy_veri_o        <= sec_veri;
    end else begin
      gy_rd_yaz_o      <= 1'b0;
    end
  end

  // Scoreboard next state: clear first, then set, so a same-cycle reservation wins.
  always_comb begin
    bekleyen_d = bekleyen_q;
    if (aktarim) begin
      bekleyen_d[sb_indeks(sec_fp, sec_adres)] = 1'b0;
    end
    if (ayir_gecerli_i && !x0_mi(ayir_fp_i, ayir_adres_i)) begin
      bekleyen_d[sb_indeks(ayir_fp_i, ayir_adres_i)] = 1'b1;
    end
  end

  // Pending-write bit register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bekleyen_q <= '0;
    else       bekleyen_q <= bekleyen_d;
  end

  function automatic logic bekliyor(input logic [SB_BOYUT-1:0] tablo,
                                    input logic fp,
                                    input logic [REG_ADRES_W-1:0] adres);
    return tablo[sb_indeks(fp, adres)] & ~x0_mi(fp, adres);
  endfunction

  // Decode stall from current scoreboard only; rs3 is always an FP operand.
  always_comb begin
    bekle_o = bekliyor(bekleyen_q, rs1_fp_oku, rs1_adres_i)
            | bekliyor(bekleyen_q, rs2_fp_oku, rs2_adres_i)
            | (rs3_oku_i & bekliyor(bekleyen_q, 1'b1, rs3_adres_i));
  end

endmodule

// File: tb/tb_geri_yazma_hakemi.sv
module tb_geri_yazma_hakemi;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     gecerli = '0;
  logic [N-1:0]     hazir;
  logic [N-1:0][4:0]  adres = '0;
  logic [N-1:0]     fp = '0;
  logic [N-1:0][31:0] veri = '0;
  logic             ayir = 1'b0;
  logic [4:0]       ayir_adres = '0;
  logic             ayir_fp = 1'b0;
  logic [4:0]       rs1 = '0, rs2 = '0, rs3 = '0;
  logic             rs1_fp = 1'b0, rs2_fp = 1'b0, rs3_oku = 1'b0;
  logic             gy_yaz;
  logic [4:0]       gy_adres;
  logic             gy_fp;
  logic [31:0]      gy_veri;
  logic             bekle;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  geri_yazma_hakemi #(.BIRIM_SAYISI(N), .VERI_GENISLIK(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .istek_gecerli_i(gecerli), .istek_hazir_o(hazir),
    .istek_adres_i(adres), .istek_fp_i(fp), .istek_veri_i(veri),
    .ayir_gecerli_i(ayir), .ayir_adres_i(ayir_adres), .ayir_fp_i(ayir_fp),
    .rs1_adres_i(rs1), .rs2_adres_i(rs2), .rs3_adres_i(rs3),
    .rs1_fp_oku(rs1_fp), .rs2_fp_oku(rs2_fp), .rs3_oku_i(rs3_oku),
    .gy_rd_yaz_o(gy_yaz), .gy_rd_adres_o(gy_adres), .gy_rd_hedef_fp_o(gy_fp),
    .gy_veri_o(gy_veri), .bekle_o(bekle)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          pend_int[32];
  bit          pend_fp[32];
  int          m_ptr;
  logic        m_yaz;
  logic [4:0]  m_adres;
  logic        m_fp;
  logic [31:0] m_veri;

  function automatic int m_grant();
    for (int d = 0; d < N; d++) begin
      if (gecerli[(m_ptr + d) % N]) return (m_ptr + d) % N;
    end
    return -1;
  endfunction

  function automatic bit m_pend(input logic f, input logic [4:0] a);
    if (f) return pend_fp[a];
    return (a != 0) && pend_int[a];
  endfunction

  function automatic logic m_bekle();
    return m_pend(rs1_fp, rs1) || m_pend(rs2_fp, rs2) || (rs3_oku && m_pend(1'b1, rs3));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin pend_int[i] = 0; pend_fp[i] = 0; end
      m_ptr = 0; m_yaz = 0; m_adres = 0; m_fp = 0; m_veri = 0;
    end else begin
      int g;
      g = m_grant();
      if (g >= 0) begin
        m_yaz   = !(fp[g] == 0 && adres[g] == 0);
        m_adres = adres[g];
        m_fp    = fp[g];
        m_veri  = veri[g];
        m_ptr   = (g + 1) % N;
        if (fp[g]) pend_fp[adres[g]] = 0; else pend_int[adres[g]] = 0;
      end else begin
        m_yaz = 0;
      end
      if (ayir && !(ayir_fp == 0 && ayir_adres == 0)) begin
        if (ayir_fp) pend_fp[ayir_adres] = 1; else pend_int[ayir_adres] = 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [N-1:0] e_hazir;
    int g;
    e_hazir = '0;
    g = m_grant();
    if (!rst && g >= 0) e_hazir[g] = 1'b1;
    chk("m_hazir",    64'(hazir),    64'(e_hazir));
    chk("m_bekle",    64'(bekle),    64'(rst ? 1'b0 : m_bekle()));
    chk("m_gy_yaz",   64'(gy_yaz),   64'(m_yaz));
    chk("m_gy_adres", 64'(gy_adres), 64'(m_adres));
    chk("m_gy_fp",    64'(gy_fp),    64'(m_fp));
    chk("m_gy_veri",  64'(gy_veri),  64'(m_veri));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    gecerli = 4'hF;
    #3;
    chk("rst_hazir", 64'(hazir), 64'h0);
    chk("rst_yaz",   64'(gy_yaz), 64'h0);
    chk("rst_veri",  64'(gy_veri), 64'h0);
    chk("rst_bekle", 64'(bekle), 64'h0);
    gecerli = '0;
    @(negedge clk); #2 rst = 1'b0;

    // Reservation vs write-back
    cyc(); ayir = 1; ayir_adres = 5; ayir_fp = 0;
    cyc(); ayir = 0; rs1 = 5; #1;
    chk("res_bekle", 64'(bekle), 64'h1);
    gecerli = 4'b0100; adres[2] = 5; fp[2] = 0; veri[2] = 32'hDEADBEEF; #1;
    chk("wb_hazir", 64'(hazir), 64'h4);
    cyc(); gecerli = '0; #1;
    chk("wb_yaz",   64'(gy_yaz), 64'h1);
    chk("wb_adres", 64'(gy_adres), 64'h5);
    chk("wb_veri",  64'(gy_veri), 64'hDEADBEEF);
    chk("wb_bekle", 64'(bekle), 64'h0);

    // Round-robin; pointer is 3 after unit 2 was granted
    for (int i = 0; i < N; i++) begin
      adres[i] = 5'(10 + i); fp[i] = 0; veri[i] = 32'h1000 + i;
    end
    gecerli = 4'hF; #1;
    chk("rr_3", 64'(hazir), 64'h8);
    cyc(); chk("rr_0", 64'(hazir), 64'h1);
    cyc(); chk("rr_1", 64'(hazir), 64'h2);
    cyc(); gecerli = 4'b1101; #1;
    chk("rr_2", 64'(hazir), 64'h4);
    cyc(); chk("rr_3b", 64'(hazir), 64'h8);
    cyc(); chk("rr_0b", 64'(hazir), 64'h1);
    cyc(); chk("rr_skip1", 64'(hazir), 64'h4);
    cyc(); gecerli = '0;

    // Simultaneous reserve and clear of f7
    cyc();
    ayir = 1; ayir_adres = 7; ayir_fp = 1;
    gecerli = 4'b1000; adres[3] = 7; fp[3] = 1; veri[3] = 32'h77; #1;
    chk("sim_hazir", 64'(hazir), 64'h8);
    cyc(); ayir = 0; gecerli = '0; rs1 = 0; rs2 = 0; rs3 = 7; rs3_oku = 1; #1;
    chk("sim_bekle", 64'(bekle), 64'h1);
    chk("sim_yaz",   64'(gy_yaz), 64'h1);
    chk("sim_fp",    64'(gy_fp), 64'h1);
    rs3_oku = 0;

    // x0 handling
    gecerli = 4'b0001; adres[0] = 0; fp[0] = 0; veri[0] = 32'h123; #1;
    chk("x0_hazir", 64'(hazir), 64'h1);
    cyc(); gecerli = '0; #1;
    chk("x0_yaz", 64'(gy_yaz), 64'h0);
    ayir = 1; ayir_adres = 0; ayir_fp = 0;
    cyc(); ayir = 0; rs1 = 0; #1;
    chk("x0_bekle", 64'(bekle), 64'h0);

    // FP/int separation
    ayir = 1; ayir_adres = 4; ayir_fp = 1;
    cyc(); ayir = 0; rs2 = 4; rs2_fp = 0; #1;
    chk("sep_int", 64'(bekle), 64'h0);
    rs2_fp = 1; #1;
    chk("sep_fp", 64'(bekle), 64'h1);

    // Reset mid-operation
    gecerli = 4'b0110; adres[1] = 9; fp[1] = 0; adres[2] = 12; fp[2] = 0; #1;
    cyc(); #1;
    chk("pre_rst_yaz", 64'(gy_yaz), 64'h1);
    rst = 1; #1;
    chk("mid_rst_yaz",   64'(gy_yaz), 64'h0);
    chk("mid_rst_bekle", 64'(bekle), 64'h0);
    chk("mid_rst_hazir", 64'(hazir), 64'h0);
    gecerli = 4'hF;
    @(negedge clk); #2 rst = 1'b0; #1;
    chk("post_rst_hazir", 64'(hazir), 64'h1);
    cyc(); cyc();
    gecerli = '0; rs2_fp = 0; rs2 = 0;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/geri_yazma_hakemi.md
# geri_yazma_hakemi

Write-back arbiter and pending-write scoreboard for the core pipeline. Multi-cycle units (ALU, multiplier, divider, FPU, load unit) compete for the single register-file write port through valid/ready handshakes. This block picks one request per cycle and drives the registered write-back stage (`gy_rd_*`) that the forwarding logic consumes. It also tracks which integer and FP registers have an in-flight write, and raises a decode stall for any source operand that is still pending.

## Interface
Parameters:
- `BIRIM_SAYISI`, 4: number of requesting units; source 0 is the in-order ALU.
- `VERI_GENISLIK`, 32: write-back data width.

Ports:
- `clk_i` in 1: clock; single clock domain.
- `rst_i` in 1: asynchronous, active-high reset.
- `istek_gecerli_i` in `BIRIM_SAYISI`: per-unit write-back request valid.
- `istek_hazir_o` out `BIRIM_SAYISI`: per-unit grant/ready; combinational.
- `istek_adres_i` in `BIRIM_SAYISI`x5: destination register per unit.
- `istek_fp_i` in `BIRIM_SAYISI`: destination is the FP file.
- `istek_veri_i` in `BIRIM_SAYISI`x`VERI_GENISLIK`: result data.
- `ayir_gecerli_i` in 1: issue-time reservation of a destination register.
- `ayir_adres_i` in 5: register to reserve.
- `ayir_fp_i` in 1: reserved register is FP.
- `rs1_adres_i`, `rs2_adres_i`, `rs3_adres_i` in 5 each: decode operand addresses.
- `rs1_fp_oku`, `rs2_fp_oku` in 1 each: operand is FP. rs3 is always FP.
- `rs3_oku_i` in 1: rs3 is used.
- `gy_rd_yaz_o` out 1: write-back stage write enable.
- `gy_rd_adres_o` out 5: write-back stage destination register.
- `gy_rd_hedef_fp_o` out 1: write-back stage destination is FP.
- `gy_veri_o` out `VERI_GENISLIK`: write-back stage data.
- `bekle_o` out 1: stall decode; at least one used operand is pending.

## Operation
- **Handshake.** A transfer occurs when `istek_gecerli_i[i] && istek_hazir_o[i]`. A unit holds valid and its payload stable until the transfer. At most one `istek_hazir_o` bit is high per cycle, and only for a valid requester.
- **Arbitration.** Round-robin over the valid requesters.
  - Pointer `oncelik_q` names the highest-priority index; the search runs upward from it with wrap-around.
  - After granting unit i, the pointer becomes (i+1) mod `BIRIM_SAYISI`.
  - If no unit is granted, the pointer holds.
- **Write-back register.** On a transfer, load `gy_rd_adres_o`, `gy_rd_hedef_fp_o` and `gy_veri_o`, and set `gy_rd_yaz_o`=1. An integer destination x0 (fp=0, adres=0) is accepted but loads `gy_rd_yaz_o`=0. With no transfer, `gy_rd_yaz_o`=0 and the other fields hold.
- **Scoreboard.**
  - 64 pending bits: index {fp, adres}.
  - A reservation sets the bit; a reservation of integer x0 is ignored.
  - A transfer clears the bit of its destination.
  - If a reservation and a clear hit the same bit in one cycle, the reservation wins and the bit stays 1.
- **Stall.** `bekle_o` = OR of the pending bits of {rs1_fp_oku, rs1}, {rs2_fp_oku, rs2}, and {1, rs3} when `rs3_oku_i`.
  - Integer x0 never stalls.
  - Combinational from current state only; a same-cycle reservation is not visible.

## Timing
- Grant: combinational, in the cycle of the request.
- Transfer at edge T: `gy_*` outputs valid in cycle T+1 (1-cycle latency). The pending bit reads 0 from cycle T+1, so the operand comes from write-back forwarding.
- Reservation at edge T: `bekle_o` reflects it from cycle T+1.
- Back-to-back transfers: one per cycle, sustained.
- Reset values (asynchronous, immediate):
  - `gy_rd_yaz_o`=0, `gy_rd_adres_o`=0, `gy_rd_hedef_fp_o`=0, `gy_veri_o`=0.
  - `oncelik_q`=0 and all pending bits 0, so `bekle_o`=0 after reset.
  - `istek_hazir_o` is 0 while `rst_i` is high.
- Reset asserted mid-transfer: the transfer is lost. Units must re-present their requests after reset.

## Structure
- Shared core package: the register-index width constant (5) and a typedef for the `{fp, adres}` scoreboard index.
- Natural sub-module: `dongusel_hakem`, a parameterised round-robin arbiter (request vector in, one-hot grant out, pointer register). The scoreboard and write-back register stay in the top module.

## Test plan
- **Reservation vs. write-back.** Reserve x5 (int), then query rs1=5 -> `bekle_o`=1. Unit 2 writes x5 with 0xDEADBEEF -> next cycle `gy_rd_yaz_o`=1, `gy_rd_adres_o`=5, `gy_veri_o`=0xDEADBEEF, `bekle_o`=0.
- **Round-robin.** All 4 units valid every cycle -> grants 0,1,2,3,0,… one per cycle. Drop unit 1 -> grants skip it.
- **Simultaneous reserve and clear.** Reserve f7 in the same cycle unit 3 writes back f7 -> the bit stays set and `bekle_o`=1 for rs3=7 with `rs3_oku_i`=1.
- **x0 handling.** Unit 0 writes integer x0 -> the handshake completes and `gy_rd_yaz_o`=0. Reserve x0 -> `bekle_o` stays 0 for rs1=0.
- **FP/int separation.** Reserve f4 only; rs2=4 with `rs2_fp_oku`=0 -> no stall; with `rs2_fp_oku`=1 -> stall.
- **Reset mid-operation.** Assert `rst_i` while a grant is active and pending bits are set -> immediately `gy_rd_yaz_o`=0, `bekle_o`=0, `istek_hazir_o`=0. After release, the first grant goes to unit 0.
